// File: rtl/readout_sequencer.sv
// readout_sequencer: counts sample_pulse strobes into integration periods.
// At the end of each period it clears the counter bank and streams the
// captured snapshot as a framed byte sequence: SYNC, SEQ, then the payload.
// Ports: clk, reset (sync, active-high), enable, sample_pulse, counts,
//        counter_clear, tx_data/tx_valid/tx_ready (byte stream), busy,
//        overrun (sticky), frame_seq.
// Option: define READOUT_CHECKSUM_EN to append an XOR checksum byte.
module readout_sequencer #(
    parameter int RESOLUTION          = 8,
    parameter int NUM_WORDS           = 36,
    parameter int INTEGRATION_SAMPLES = 1024,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            sample_pulse,
    input  logic [NUM_WORDS*RESOLUTION-1:0] counts,
    output logic                            counter_clear,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic                            overrun,
    output logic [7:0]                      frame_seq
);

    localparam int PAYLOAD_W     = NUM_WORDS * RESOLUTION;
    localparam int PAYLOAD_BYTES = PAYLOAD_W / 8;
    localparam int IDX_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int SCNT_W = $clog2(INTEGRATION_SAMPLES);

`ifdef READOUT_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, SEQ, DATA} state_t;
`endif

    state_t              state;
    state_t              state_next;
    logic                enable_q;
    logic [SCNT_W-1:0]   scnt;
    logic [IDX_W-1:0]    byte_idx;
    logic [PAYLOAD_W-1:0] shadow;
    logic [7:0]          seq_latch;
    logic [7:0]          payload_byte;
    logic                rise;
    logic                wrap;
    logic                eoi;
    logic                last_byte;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    // A fresh enable edge restarts the period; it takes priority over a
    // coincident sample pulse, so it can never also produce an EOI.
    assign rise      = enable & ~enable_q;
    assign wrap      = (scnt == SCNT_W'(INTEGRATION_SAMPLES - 1));
    assign eoi       = enable & ~rise & sample_pulse & wrap;
    assign last_byte = (byte_idx == IDX_W'(PAYLOAD_BYTES - 1));
    assign busy      = (state != IDLE);

    // Flat snapshot byte i is already word-major, LSB byte first.
    always_comb begin
        payload_byte = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_idx == IDX_W'(i)) begin
                payload_byte = shadow[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            enable_q      <= 1'b0;
            scnt          <= '0;
            counter_clear <= 1'b0;
            frame_seq     <= '0;
            overrun       <= 1'b0;
            byte_idx      <= '0;
            shadow        <= '0;
            seq_latch     <= '0;
        end else begin
            state         <= state_next;
            enable_q      <= enable;
            counter_clear <= rise | eoi;

            if (!enable || rise) begin
                scnt <= '0;
            end else if (sample_pulse) begin
                scnt <= wrap ? '0 : scnt + 1'b1;
            end

            if (eoi) begin
                frame_seq <= frame_seq + 8'd1;
                if (state == IDLE) begin
                    shadow    <= counts;
                    seq_latch <= frame_seq + 8'd1;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (state == DATA && tx_ready) begin
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
            end
        end
    end

`ifdef READOUT_CHECKSUM_EN
    // Running XOR over the SEQ byte and every accepted payload byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (state == SEQ && tx_ready) begin
            csum <= seq_latch;
        end else if (state == DATA && tx_ready) begin
            csum <= csum ^ payload_byte;
        end
    end
`endif

    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = '0;
        unique case (state)
            IDLE: begin
                if (eoi) state_next = SYNC;
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) state_next = SEQ;
            end
            SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_latch;
                if (tx_ready) state_next = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = payload_byte;
                if (tx_ready && last_byte) begin
`ifdef READOUT_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: scoreboard bench for readout_sequencer with a
// period/frame-level reference model and a decoupled byte monitor.
module tb_readout_sequencer;

    localparam int IS  = 4;
    localparam int NW  = 2;
    localparam int RES = 16;
    localparam int PB  = NW * RES / 8;
`ifdef READOUT_CHECKSUM_EN
    localparam int FL  = PB + 3;
`else
    localparam int FL  = PB + 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_pulse;
    logic [31:0] counts;
    logic        counter_clear;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_seq;

    readout_sequencer #(
        .RESOLUTION(RES),
        .NUM_WORDS(NW),
        .INTEGRATION_SAMPLES(IS),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_pulse(sample_pulse),
        .counts(counts),
        .counter_clear(counter_clear),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .overrun(overrun),
        .frame_seq(frame_seq)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] exp_q[$];

    // Reference model: pulses counted modulo the period, frames as byte
    // lists, the link as "bytes of the current frame still to send".
    int       pulses = 0;
    bit       en_prev = 1'b0;
    int       left = 0;
    logic [7:0] seq = 8'd0;
    bit       ovr = 1'b0;
    bit       exp_clear = 1'b0;
    int       clears = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit sp,
                        input bit rdy, input logic [31:0] cnt);
        bit rise;
        bit eoi;
        int lb;
        logic [7:0] cs;
        logic [7:0] b;
        reset        = rst;
        enable       = en;
        sample_pulse = sp;
        tx_ready     = rst ? 1'b0 : rdy;
        counts       = cnt;
        if (rst) begin
            pulses = 0; en_prev = 0; left = 0; seq = 0;
            ovr = 0; exp_clear = 0;
            exp_q.delete();
        end else begin
            rise = en && !en_prev;
            eoi  = en && !rise && sp && (pulses == IS - 1);
            if (!en || rise) pulses = 0;
            else if (sp) pulses = (pulses + 1) % IS;
            lb = left;
            if (left > 0 && rdy) left--;
            if (eoi) begin
                seq = seq + 8'd1;
                if (lb == 0) begin
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(seq);
                    cs = seq;
                    for (int i = 0; i < PB; i++) begin
                        b = cnt[i*8 +: 8];
                        exp_q.push_back(b);
                        cs = cs ^ b;
                    end
`ifdef READOUT_CHECKSUM_EN
                    exp_q.push_back(cs);
`endif
                    left = FL;
                end else begin
                    ovr = 1'b1;
                end
            end
            exp_clear = rise || eoi;
            en_prev = en;
        end
        @(posedge clk);
        #1;
        if (exp_clear) clears++;
        check("counter_clear", {31'd0, counter_clear}, {31'd0, exp_clear});
        check("busy", {31'd0, busy}, {31'd0, left > 0});
        check("tx_valid", {31'd0, tx_valid}, {31'd0, left > 0});
        check("overrun", {31'd0, overrun}, {31'd0, ovr});
        check("frame_seq", {24'd0, frame_seq}, {24'd0, seq});
        if (rst) check("reset_tx_data", {24'd0, tx_data}, 32'd0);
    endtask

    // Monitor: pops one expected byte per accepted transfer and checks
    // that a stalled byte does not change until it is taken.
    bit         held = 1'b0;
    logic [7:0] held_data = 8'd0;
    always @(negedge clk) begin
        if (tx_valid) begin
            if (held) check("stall_hold", {24'd0, tx_data}, {24'd0, held_data});
            if (tx_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none",
                             tx_data);
                end else begin
                    check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end else begin
                held = 1'b1;
                held_data = tx_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    localparam logic [31:0] CNT = 32'h1234_ABCD;

    task automatic pulses_n(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 1, 1, rdy, CNT);
    endtask

    task automatic idle_n(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 1, 0, rdy, CNT);
    endtask

    initial begin
        reset = 1; enable = 0; sample_pulse = 0; tx_ready = 0; counts = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, CNT);

        // Basic frame: A5 01 CD AB 34 12
        step(0, 1, 0, 1, CNT);
        pulses_n(4, 1);
        idle_n(10, 1);
        check("first_frame_seq", {24'd0, frame_seq}, 32'd1);

        // Ready toggling mid-frame
        pulses_n(4, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, i[0], CNT);

        // Overrun: second EOI while first frame is stalled
        pulses_n(4, 0);
        pulses_n(4, 0);
        check("overrun_seq", {24'd0, frame_seq}, 32'd4);
        check("overrun_flag", {31'd0, overrun}, 32'd1);
        idle_n(10, 1);
        pulses_n(4, 1);
        idle_n(10, 1);

        // Reset while sending payload
        pulses_n(4, 1);
        idle_n(3, 1);
        step(1, 1, 0, 1, CNT);
        check("post_reset_overrun", {31'd0, overrun}, 32'd0);
        pulses_n(4, 1);
        idle_n(10, 1);

        // Enable edge coincident with a pulse
        clears = 0;
        step(0, 0, 0, 1, CNT);
        step(0, 1, 1, 1, CNT);
        pulses_n(3, 1);
        check("edge_no_eoi", {31'd0, busy}, 32'd0);
        pulses_n(1, 1);
        check("edge_clear_count", clears, 32'd2);
        idle_n(10, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) != 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) < 7),
                 $urandom);
        end

        // Drain with the sequencer idle
        for (int i = 0; i < 4 * FL; i++) step(0, 0, 0, 1, 32'd0);
        check("drain_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Schedules correlator integration periods and streams each period's counter snapshot to the UART transmitter as a framed byte sequence. Sits between the sample clock generator, the pulse/correlation counter bank and the byte-wide UART TX. Replaces free-running integration timing with a sample-counted period, an explicit counter-clear strobe and a valid/ready byte stream.

## Interface
- RESOLUTION, 8, bits per counter word; must be 8, 16, 24 or 32
- NUM_WORDS, 36, counter words per snapshot (correlators plus single-input counters)
- INTEGRATION_SAMPLES, 1024, sample_pulse strobes per integration period; ≥2
- SYNC_BYTE, 8'hA5, frame start marker

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run integrations; low holds sample counter at 0
- sample_pulse  in  1  one-cycle strobe from sample clock generator
- counts  in  NUM_WORDS*RESOLUTION  counter bank outputs; word k at [k*RESOLUTION+:RESOLUTION]
- counter_clear  out  1  one-cycle strobe; counter bank clears on it
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  frame in progress (state ≠ IDLE)
- overrun  out  1  sticky: snapshot dropped because a frame was still in progress
- frame_seq  out  8  sequence number of most recent integration

## Operation
- Sample counter scnt, width clog2(INTEGRATION_SAMPLES). enable=1 and sample_pulse=1: scnt increments; at INTEGRATION_SAMPLES-1 it wraps to 0 and marks end-of-integration (EOI).
- enable 0→1 edge: scnt=0, one counter_clear pulse, no frame. enable=0: no EOI; frame in progress completes.
- On EOI: counter_clear pulses; frame_seq increments (mod 256) regardless of drop.
  - If state IDLE: counts latched into shadow register, frame starts.
  - Else: snapshot discarded, overrun set; current frame unaffected.
- FSM: IDLE → SYNC (SYNC_BYTE) → SEQ (frame_seq at capture) → DATA (NUM_WORDS*RESOLUTION/8 bytes, word 0 first, each word LSB byte first) → IDLE. Each state advances only on tx_valid&tx_ready.
- Byte index counter in DATA, width clog2(total payload bytes); last byte leaves DATA.
- tx_valid high in every state but IDLE; tx_data constant while tx_valid&!tx_ready.
- Gap in received frame_seq indicates dropped snapshots.

## Timing
- Reset values: counter_clear=0, tx_valid=0, tx_data=0, busy=0, overrun=0, frame_seq=0, scnt=0, state IDLE. Reset mid-frame aborts immediately, no partial bytes after.
- EOI detected in cycle T (sample_pulse sampled at edge ending T): counter_clear=1 during T+1 only; shadow latch on the edge ending T (counts of cycle T).
- First byte: tx_valid=1 with SYNC_BYTE in T+1; busy=1 from T+1.
- With tx_ready held 1: one byte per cycle; frame length 2+payload (+1 with checksum) cycles; busy drops the cycle after last transfer.
- EOI in the same cycle as the final byte transfer: state counts as busy → dropped, overrun set.
- enable edge and sample_pulse in same cycle: edge wins, scnt=0.
- overrun clears only on reset.

## Configuration
- READOUT_CHECKSUM_EN defined: CSUM state after DATA emits one byte = XOR of SEQ byte and all payload bytes; frame length +1.
- Undefined: DATA → IDLE directly; no checksum logic.

## Test plan
- INTEGRATION_SAMPLES=4, NUM_WORDS=2, RESOLUTION=16, counts=32'h1234_ABCD, tx_ready=1, 4 sample pulses → counter_clear once, bytes A5,01,CD,AB,34,12; busy low after.
- tx_ready toggled every other cycle mid-frame → tx_data stable while unaccepted, same byte sequence, no loss or duplicate.
- tx_ready=0 through a second EOI → overrun=1, frame_seq=2, first frame resumes intact; next frame carries seq 03.
- Checksum build, same stimulus as first → extra byte 01^CD^AB^34^12=0x41.
- Reset asserted during DATA → tx_valid=0 next cycle, all outputs at reset values; next frame starts with SYNC, seq 01.
- enable 0→1 with coincident sample_pulse → single counter_clear, scnt=0, first EOI after exactly 4 further pulses.
